// File: rtl/nx_indirect_access_mw_cntrl.sv
`timescale 1ns/1ps
// Indirect-access controller: stages a wide table entry through register-width data words and
// sequences READ/WRITE/RESET/INIT(_INC) accesses to one of N_TABLES tables over a shared memory port.
// Latency: status visible one cycle after a command; WRITE completes on grant; READ data lands grant+1.
// Backpressure: memory accesses wait for grant; a wait of 2^N_TIMER_BITS-1 cycles aborts with TMO.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr_stb/reg_addr/wr_dat     CSR register write (command word or staging data words)
//   cmnd_op/addr/table_id      command fields, sampled on a write to CMND_ADDRESS
//   addr_limit                 per-table last valid entry address, AW bits per table
//   stat_*                     status code, word count, selected table limit, latched table id
//   rd_dat                     staging buffer contents
//   sw_cs/we/add/table_id/wdat memory request; sw_rdat returned the cycle after grant
//   grant/yield                port grant from datapath; yield asks the datapath to release it
//   reset                      one-cycle pulse while a RESET write is presented
//
// Optional build macro: NX_IA_SIM_TMO_EN enables op 14 (SIM_TMO), which masks grant until the
// next timeout. Without it op 14 is an undefined opcode.

module nx_indirect_access_mw_cntrl #(
    parameter int                         N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 11'h40C,
    parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS    = 11'h410,
    parameter int                         N_WORD_BITS     = 32,
    parameter int                         N_DATA_BITS     = 128,
    parameter int                         N_TABLES        = 2,
    parameter int                         N_ENTRIES       = 64,
    parameter int                         N_TIMER_BITS    = 4,
    localparam int N_WORDS = (N_DATA_BITS + N_WORD_BITS - 1) / N_WORD_BITS,
    localparam int TW      = (N_TABLES > 1) ? $clog2(N_TABLES) : 1,
    localparam int AW      = $clog2(N_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
    input  logic [N_WORD_BITS-1:0]     wr_dat,
    input  logic [3:0]                 cmnd_op,
    input  logic [AW-1:0]              cmnd_addr,
    input  logic [TW-1:0]              cmnd_table_id,
    input  logic [N_TABLES*AW-1:0]     addr_limit,
    output logic [2:0]                 stat_code,
    output logic [4:0]                 stat_datawords,
    output logic [AW-1:0]              stat_addr,
    output logic [TW-1:0]              stat_table_id,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    output logic                       sw_cs,
    output logic                       sw_we,
    output logic [AW-1:0]              sw_add,
    output logic [TW-1:0]              sw_table_id,
    output logic [N_DATA_BITS-1:0]     sw_wdat,
    input  logic [N_DATA_BITS-1:0]     sw_rdat,
    input  logic                       grant,
    output logic                       yield,
    output logic                       reset
);

    localparam int BUF_BITS = N_WORDS * N_WORD_BITS;
    // The top staging word only carries the bits that exist in a table entry.
    localparam logic [N_WORD_BITS-1:0] TOP_MASK = {N_WORD_BITS{1'b1}} >> (BUF_BITS - N_DATA_BITS);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_READ      = 4'd1;
    localparam logic [3:0] OP_WRITE     = 4'd2;
    localparam logic [3:0] OP_ENABLE    = 4'd3;
    localparam logic [3:0] OP_DISABLE   = 4'd4;
    localparam logic [3:0] OP_RESET     = 4'd5;
    localparam logic [3:0] OP_INIT      = 4'd6;
    localparam logic [3:0] OP_INIT_INC  = 4'd7;
    localparam logic [3:0] OP_SET_START = 4'd8;
`ifdef NX_IA_SIM_TMO_EN
    localparam logic [3:0] OP_SIM_TMO   = 4'd14;
`endif
    localparam logic [3:0] OP_ACK_ERROR = 4'd15;

    localparam logic [2:0] STAT_RDY = 3'd0;
    localparam logic [2:0] STAT_BSY = 3'd1;
    localparam logic [2:0] STAT_TMO = 3'd2;
    localparam logic [2:0] STAT_OVR = 3'd3;
    localparam logic [2:0] STAT_NXM = 3'd4;
    localparam logic [2:0] STAT_UOP = 3'd5;
    localparam logic [2:0] STAT_PDN = 3'd7;

    typedef enum logic [2:0] {
        ST_READY,
        ST_DO_WRITE,
        ST_DO_READ,
        ST_READ_DONE,
        ST_DO_RESET,
        ST_DO_INIT,
        ST_POWERDOWN,
        ST_ERROR
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [2:0]                      r_stat;
    logic [2:0]                      w_stat_nxt;
    logic [2:0]                      w_err_code;
    logic [N_TIMER_BITS-1:0]         r_timer;
    logic [AW-1:0]                   r_addr;
    logic [AW-1:0]                   r_init_ptr;
    logic [TW-1:0]                   r_table_id;
    logic                            r_init_inc;
    logic                            r_err_from_pdn;
    logic [N_WORDS-1:0][N_WORD_BITS-1:0] r_buf;
    logic [BUF_BITS-1:0]             w_buf_flat;
    logic [BUF_BITS-1:0]             w_rdat_ext;

    logic                            w_cmd_wr;
    logic                            w_cmd_issued;
    logic                            w_op_undef;
    logic                            w_tid_ok;
    logic [AW-1:0]                   w_cmd_limit;
    logic                            w_badaddr;
    logic                            w_busy;
    logic                            w_busy_wait;
    logic                            w_tmo;
    logic                            w_grant;
    logic                            w_uop;
    logic                            w_nxm;
    logic                            w_ovr;
    logic [N_REG_ADDR_BITS-1:0]      w_dat_idx;
    logic                            w_dat_wr;
    logic                            w_inc_word0;
    logic [AW-1:0]                   w_stat_addr;

    // ------------------------------------------------------------------
    // Command decode and address check
    // ------------------------------------------------------------------
    assign w_cmd_wr = wr_stb && (reg_addr == CMND_ADDRESS);

`ifdef NX_IA_SIM_TMO_EN
    assign w_cmd_issued = w_cmd_wr && (cmnd_op != OP_NOP) && (cmnd_op != OP_SIM_TMO);
`else
    assign w_cmd_issued = w_cmd_wr && (cmnd_op != OP_NOP);
`endif

    always_comb begin
        w_op_undef = 1'b1;
        case (cmnd_op)
            OP_NOP, OP_READ, OP_WRITE, OP_ENABLE, OP_DISABLE, OP_RESET,
            OP_INIT, OP_INIT_INC, OP_SET_START, OP_ACK_ERROR: w_op_undef = 1'b0;
`ifdef NX_IA_SIM_TMO_EN
            OP_SIM_TMO:                                       w_op_undef = 1'b0;
`endif
            default:                                          w_op_undef = 1'b1;
        endcase
    end

    // Table lookup by loop so a table id past N_TABLES simply matches nothing.
    always_comb begin
        w_tid_ok    = 1'b0;
        w_cmd_limit = '0;
        for (int t = 0; t < N_TABLES; t++) begin
            if (cmnd_table_id == TW'(t)) begin
                w_tid_ok    = 1'b1;
                w_cmd_limit = addr_limit[t*AW +: AW];
            end
        end
    end

    assign w_badaddr = w_cmd_issued && (!w_tid_ok || (cmnd_addr > w_cmd_limit));

    // ------------------------------------------------------------------
    // Busy / timeout / grant qualification
    // ------------------------------------------------------------------
    assign w_busy = (r_state == ST_DO_WRITE) || (r_state == ST_DO_READ) ||
                    (r_state == ST_READ_DONE) || (r_state == ST_DO_RESET) ||
                    (r_state == ST_DO_INIT);
    assign w_busy_wait = (r_state == ST_DO_WRITE) || (r_state == ST_DO_READ) ||
                         (r_state == ST_DO_INIT);
    assign w_tmo = w_busy_wait && (&r_timer);

`ifdef NX_IA_SIM_TMO_EN
    logic r_sim_mask;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sim_mask <= 1'b0;
        end else if (w_tmo) begin
            r_sim_mask <= 1'b0;
        end else if (w_cmd_wr && (cmnd_op == OP_SIM_TMO)) begin
            r_sim_mask <= 1'b1;
        end
    end
    assign w_grant = grant && !r_sim_mask && !w_tmo;
`else
    // The request is withdrawn in the timeout cycle, so a late grant is not honoured.
    assign w_grant = grant && !w_tmo;
`endif

    // Errors only arise where commands are acted on: ERROR holds its code,
    // POWERDOWN ignores everything except ENABLE (but still checks addresses).
    assign w_uop = w_cmd_wr && w_op_undef && (r_state != ST_POWERDOWN) && (r_state != ST_ERROR);
    assign w_nxm = w_badaddr && (r_state != ST_ERROR);
    assign w_ovr = w_cmd_issued && w_busy;

    always_comb begin
        if (w_uop) begin
            w_err_code = STAT_UOP;
        end else if (w_nxm) begin
            w_err_code = STAT_NXM;
        end else if (w_tmo) begin
            w_err_code = STAT_TMO;
        end else begin
            w_err_code = STAT_OVR;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_READY: begin
                if (w_cmd_issued) begin
                    case (cmnd_op)
                        OP_WRITE:              w_state_nxt = ST_DO_WRITE;
                        OP_READ:               w_state_nxt = ST_DO_READ;
                        OP_RESET:              w_state_nxt = ST_DO_RESET;
                        OP_INIT, OP_INIT_INC:  w_state_nxt = ST_DO_INIT;
                        OP_DISABLE:            w_state_nxt = ST_POWERDOWN;
                        default:               w_state_nxt = ST_READY;
                    endcase
                end
            end
            ST_DO_WRITE:  if (w_grant) w_state_nxt = ST_READY;
            ST_DO_READ:   if (w_grant) w_state_nxt = ST_READ_DONE;
            ST_READ_DONE: w_state_nxt = ST_READY;
            ST_DO_RESET:  w_state_nxt = ST_READY;
            ST_DO_INIT:   if (w_grant && (r_init_ptr == r_addr)) w_state_nxt = ST_READY;
            ST_POWERDOWN: if (w_cmd_issued && (cmnd_op == OP_ENABLE)) w_state_nxt = ST_READY;
            ST_ERROR: begin
                if (w_cmd_issued && (cmnd_op == OP_ACK_ERROR)) begin
                    w_state_nxt = r_err_from_pdn ? ST_POWERDOWN : ST_READY;
                end
            end
            default:      w_state_nxt = ST_READY;
        endcase
        if (w_uop || w_nxm || w_tmo || w_ovr) begin
            w_state_nxt = ST_ERROR;
        end
    end

    always_comb begin
        case (w_state_nxt)
            ST_READY:     w_stat_nxt = STAT_RDY;
            ST_POWERDOWN: w_stat_nxt = STAT_PDN;
            ST_ERROR:     w_stat_nxt = (r_state == ST_ERROR) ? r_stat : w_err_code;
            default:      w_stat_nxt = STAT_BSY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat         <= STAT_RDY;
            r_err_from_pdn <= 1'b0;
            r_timer        <= '0;
        end else begin
            r_stat <= w_stat_nxt;
            if ((w_state_nxt == ST_ERROR) && (r_state != ST_ERROR)) begin
                r_err_from_pdn <= (r_state == ST_POWERDOWN);
            end
            // Counts consecutive ungranted wait cycles of the current access only.
            if (w_busy_wait && !w_grant && (w_state_nxt == r_state)) begin
                r_timer <= r_timer + N_TIMER_BITS'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command field capture and init pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table_id <= '0;
            r_addr     <= '0;
            r_init_inc <= 1'b0;
            r_init_ptr <= '0;
        end else begin
            if (w_cmd_issued) begin
                r_table_id <= cmnd_table_id;
            end
            if ((r_state == ST_READY) && w_cmd_issued) begin
                r_addr     <= cmnd_addr;
                r_init_inc <= (cmnd_op == OP_INIT_INC);
            end
            if (r_state == ST_DO_RESET) begin
                r_init_ptr <= '0;
            end else if ((r_state == ST_DO_INIT) && w_grant) begin
                r_init_ptr <= r_init_ptr + AW'(1);
            end else if ((r_state == ST_READY) && w_cmd_issued && !w_badaddr &&
                         (cmnd_op == OP_SET_START)) begin
                r_init_ptr <= cmnd_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Staging buffer
    // ------------------------------------------------------------------
    assign w_dat_idx   = reg_addr - DATA_ADDRESS;
    // Buffer is owned by the read path while a read result is pending.
    assign w_dat_wr    = wr_stb && (reg_addr >= DATA_ADDRESS) &&
                         (w_dat_idx < N_REG_ADDR_BITS'(N_WORDS)) &&
                         (r_state != ST_DO_READ) && (r_state != ST_READ_DONE);
    assign w_inc_word0 = (r_state == ST_DO_INIT) && r_init_inc && w_grant;

    always_comb begin
        w_rdat_ext                  = '0;
        w_rdat_ext[N_DATA_BITS-1:0] = sw_rdat;
    end

    function automatic logic [N_WORD_BITS-1:0] word_mask(input int idx);
        return (idx == N_WORDS - 1) ? TOP_MASK : {N_WORD_BITS{1'b1}};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
        end else if (r_state == ST_READ_DONE) begin
            r_buf <= w_rdat_ext;
        end else begin
            if (w_inc_word0) begin
                r_buf[0] <= (r_buf[0] + N_WORD_BITS'(1)) & word_mask(0);
            end
            // A register write to word 0 takes precedence over the INIT_INC step.
            for (int i = 0; i < N_WORDS; i++) begin
                if (w_dat_wr && (w_dat_idx == N_REG_ADDR_BITS'(i))) begin
                    r_buf[i] <= wr_dat & word_mask(i);
                end
            end
        end
    end

    assign w_buf_flat = r_buf;
    assign rd_dat     = w_buf_flat[N_DATA_BITS-1:0];

    // ------------------------------------------------------------------
    // Memory port and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        sw_cs   = 1'b0;
        sw_we   = 1'b0;
        sw_add  = r_addr;
        sw_wdat = rd_dat;
        reset   = 1'b0;
        case (r_state)
            ST_DO_WRITE: begin
                sw_cs = !w_tmo;
                sw_we = !w_tmo;
            end
            ST_DO_READ: begin
                sw_cs = !w_tmo;
            end
            ST_DO_RESET: begin
                sw_cs   = 1'b1;
                sw_we   = 1'b1;
                sw_add  = '0;
                sw_wdat = '0;
                reset   = 1'b1;
            end
            ST_DO_INIT: begin
                sw_cs  = !w_tmo;
                sw_we  = !w_tmo;
                sw_add = r_init_ptr;
            end
            default: begin
                sw_cs = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_stat_addr = '0;
        for (int t = 0; t < N_TABLES; t++) begin
            if (r_table_id == TW'(t)) begin
                w_stat_addr = addr_limit[t*AW +: AW];
            end
        end
        if (r_state == ST_POWERDOWN) begin
            w_stat_addr = '0;
        end
    end

    assign yield          = r_timer[N_TIMER_BITS-1];
    assign sw_table_id    = r_table_id;
    assign stat_code      = r_stat;
    assign stat_datawords = 5'(N_WORDS);
    assign stat_addr      = w_stat_addr;
    assign stat_table_id  = r_table_id;

endmodule

// File: tb/tb_nx_indirect_access_mw_cntrl.sv
`timescale 1ns/1ps
// Directed bench for nx_indirect_access_mw_cntrl: inputs change and outputs are
// checked on the falling clock edge; expected values are hand-computed constants.

module tb_nx_indirect_access_mw_cntrl;

    localparam logic [10:0] CMND = 11'h40C;
    localparam logic [10:0] DATA = 11'h410;

    localparam logic [3:0] OP_READ = 4'd1, OP_WRITE = 4'd2, OP_ENABLE = 4'd3, OP_DISABLE = 4'd4;
    localparam logic [3:0] OP_RESET = 4'd5, OP_INIT = 4'd6, OP_INIT_INC = 4'd7, OP_SET_START = 4'd8;
    localparam logic [3:0] OP_ACK = 4'd15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_stb = 1'b0;
    logic [10:0]  reg_addr = '0;
    logic [31:0]  wr_dat = '0;
    logic [3:0]   cmnd_op = '0;
    logic [5:0]   cmnd_addr = '0;
    logic [0:0]   cmnd_table_id = '0;
    logic [11:0]  addr_limit = {6'd63, 6'd63};
    logic [2:0]   stat_code;
    logic [4:0]   stat_datawords;
    logic [5:0]   stat_addr;
    logic [0:0]   stat_table_id;
    logic [127:0] rd_dat;
    logic         sw_cs, sw_we;
    logic [5:0]   sw_add;
    logic [0:0]   sw_table_id;
    logic [127:0] sw_wdat;
    logic [127:0] sw_rdat = '0;
    logic         grant = 1'b0;
    logic         yield;
    logic         reset;

    int n_pass = 0;
    int n_total = 0;

    nx_indirect_access_mw_cntrl dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .reg_addr(reg_addr), .wr_dat(wr_dat),
        .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id),
        .addr_limit(addr_limit), .stat_code(stat_code), .stat_datawords(stat_datawords),
        .stat_addr(stat_addr), .stat_table_id(stat_table_id), .rd_dat(rd_dat),
        .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_table_id(sw_table_id),
        .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .grant(grant), .yield(yield), .reset(reset)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One register write; called and returns on a falling edge.
    task automatic reg_wr(input logic [10:0] a, input logic [31:0] d);
        reg_addr = a; wr_dat = d; wr_stb = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [5:0] a, input logic t);
        cmnd_op = op; cmnd_addr = a; cmnd_table_id = t;
        reg_wr(CMND, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_total++; if (stat_code !== 3'd0) $display("FAIL rst_stat: got %0d want 0", stat_code); else n_pass++;
        n_total++; if (sw_cs !== 1'b0 || sw_we !== 1'b0) $display("FAIL rst_cs: got cs=%b we=%b want 0 0", sw_cs, sw_we); else n_pass++;
        n_total++; if (reset !== 1'b0 || yield !== 1'b0) $display("FAIL rst_pulse: got reset=%b yield=%b want 0 0", reset, yield); else n_pass++;
        n_total++; if (rd_dat !== 128'h0) $display("FAIL rst_buf: got %h want 0", rd_dat); else n_pass++;
        n_total++; if (stat_datawords !== 5'd4) $display("FAIL rst_words: got %0d want 4", stat_datawords); else n_pass++;
        n_total++; if (stat_table_id !== 1'b0) $display("FAIL rst_tid: got %0d want 0", stat_table_id); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        reg_wr(DATA + 11'd0, 32'h11111111);
        reg_wr(DATA + 11'd1, 32'h22222222);
        reg_wr(DATA + 11'd2, 32'h33333333);
        reg_wr(DATA + 11'd3, 32'h44444444);
        cmd(OP_WRITE, 6'd5, 1'b1);
        n_total++; if (stat_code !== 3'd1) $display("FAIL wr_bsy: got %0d want 1", stat_code); else n_pass++;
        n_total++; if (sw_cs !== 1'b1 || sw_we !== 1'b1) $display("FAIL wr_cs: got cs=%b we=%b want 1 1", sw_cs, sw_we); else n_pass++;
        n_total++; if (sw_wdat !== 128'h44444444_33333333_22222222_11111111) $display("FAIL wr_wdat: got %h want 44444444333333332222222211111111", sw_wdat); else n_pass++;
        n_total++; if (sw_add !== 6'd5 || sw_table_id !== 1'b1) $display("FAIL wr_addr: got add=%0d tid=%0d want 5 1", sw_add, sw_table_id); else n_pass++;
        @(negedge clk);
        n_total++; if (stat_code !== 3'd1 || sw_cs !== 1'b1) $display("FAIL wr_wait: got stat=%0d cs=%b want 1 1", stat_code, sw_cs); else n_pass++;
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        n_total++; if (stat_code !== 3'd0 || sw_cs !== 1'b0) $display("FAIL wr_done: got stat=%0d cs=%b want 0 0", stat_code, sw_cs); else n_pass++;
        n_total++; if (stat_table_id !== 1'b1) $display("FAIL wr_tid: got %0d want 1", stat_table_id); else n_pass++;
    endtask

    task automatic test_read();
        sw_rdat = 128'hA5;
        grant = 1'b1;
        cmd(OP_READ, 6'd5, 1'b1);
        n_total++; if (sw_cs !== 1'b1 || sw_we !== 1'b0) $display("FAIL rd_cs: got cs=%b we=%b want 1 0", sw_cs, sw_we); else n_pass++;
        @(negedge clk);
        grant = 1'b0;
        n_total++; if (rd_dat !== 128'h44444444_33333333_22222222_11111111 || stat_code !== 3'd1) $display("FAIL rd_mid: got dat=%h stat=%0d want old data, 1", rd_dat, stat_code); else n_pass++;
        // A data write while the read result is pending must be dropped.
        reg_wr(DATA + 11'd1, 32'hDEADBEEF);
        n_total++; if (rd_dat !== 128'hA5 || stat_code !== 3'd0) $display("FAIL rd_done: got dat=%h stat=%0d want a5 0", rd_dat, stat_code); else n_pass++;
    endtask

    task automatic test_nxm();
        addr_limit = {6'd63, 6'd9};
        cmd(OP_WRITE, 6'd10, 1'b0);
        n_total++; if (stat_code !== 3'd4 || sw_cs !== 1'b0) $display("FAIL nxm: got stat=%0d cs=%b want 4 0", stat_code, sw_cs); else n_pass++;
        @(negedge clk);
        n_total++; if (sw_cs !== 1'b0 || stat_code !== 3'd4) $display("FAIL nxm_hold: got cs=%b stat=%0d want 0 4", sw_cs, stat_code); else n_pass++;
        cmd(OP_ACK, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd0) $display("FAIL nxm_ack: got %0d want 0", stat_code); else n_pass++;
        cmd(OP_WRITE, 6'd9, 1'b0);
        n_total++; if (stat_code !== 3'd1 || sw_add !== 6'd9) $display("FAIL nxm_edge: got stat=%0d add=%0d want 1 9", stat_code, sw_add); else n_pass++;
        grant = 1'b1;
        @(negedge clk);
        grant = 1'b0;
        n_total++; if (stat_code !== 3'd0) $display("FAIL nxm_edge_done: got %0d want 0", stat_code); else n_pass++;
    endtask

    task automatic test_uop();
        cmd(4'd9, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd5) $display("FAIL uop9: got %0d want 5", stat_code); else n_pass++;
        cmd(OP_ACK, 6'd0, 1'b0);
`ifndef NX_IA_SIM_TMO_EN
        cmd(4'd14, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd5) $display("FAIL uop14: got %0d want 5", stat_code); else n_pass++;
        cmd(OP_ACK, 6'd0, 1'b0);
`endif
        n_total++; if (stat_code !== 3'd0) $display("FAIL uop_ack: got %0d want 0", stat_code); else n_pass++;
    endtask

    task automatic test_init_inc();
        cmd(OP_SET_START, 6'd2, 1'b0);
        n_total++; if (stat_code !== 3'd0) $display("FAIL set_start: got %0d want 0", stat_code); else n_pass++;
        reg_wr(DATA, 32'd7);
        grant = 1'b1;
        cmd(OP_INIT_INC, 6'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (sw_cs !== 1'b1 || sw_we !== 1'b1 || sw_add !== 6'(2 + k) || sw_wdat !== 128'(7 + k))
                $display("FAIL init_inc_%0d: got cs=%b we=%b add=%0d wdat=%h want 1 1 %0d %0d", k, sw_cs, sw_we, sw_add, sw_wdat, 2 + k, 7 + k);
            else n_pass++;
            @(negedge clk);
        end
        grant = 1'b0;
        n_total++; if (stat_code !== 3'd0 || sw_cs !== 1'b0) $display("FAIL init_inc_done: got stat=%0d cs=%b want 0 0", stat_code, sw_cs); else n_pass++;
        n_total++; if (rd_dat !== 128'd10) $display("FAIL init_inc_buf: got %h want a", rd_dat); else n_pass++;
    endtask

    task automatic test_timeout();
        grant = 1'b0;
        cmd(OP_WRITE, 6'd3, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 7) begin
                n_total++; if (yield !== 1'b0) $display("FAIL yield_t7: got %b want 0", yield); else n_pass++;
            end
            if (k == 8) begin
                n_total++; if (yield !== 1'b1) $display("FAIL yield_t8: got %b want 1", yield); else n_pass++;
            end
            if (k == 14) begin
                n_total++; if (sw_cs !== 1'b1 || stat_code !== 3'd1) $display("FAIL tmo_t14: got cs=%b stat=%0d want 1 1", sw_cs, stat_code); else n_pass++;
            end
            if (k == 15) begin
                n_total++; if (sw_cs !== 1'b0) $display("FAIL tmo_drop: got cs=%b want 0", sw_cs); else n_pass++;
            end
            if (k == 16) begin
                n_total++; if (stat_code !== 3'd2 || yield !== 1'b0) $display("FAIL tmo: got stat=%0d yield=%b want 2 0", stat_code, yield); else n_pass++;
            end
        end
        cmd(OP_ACK, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd0) $display("FAIL tmo_ack: got %0d want 0", stat_code); else n_pass++;
    endtask

    task automatic test_overrun();
        cmd(OP_WRITE, 6'd1, 1'b0);
        n_total++; if (stat_code !== 3'd1) $display("FAIL ovr_bsy: got %0d want 1", stat_code); else n_pass++;
        cmd(OP_READ, 6'd1, 1'b0);
        n_total++; if (stat_code !== 3'd3 || sw_cs !== 1'b0) $display("FAIL ovr: got stat=%0d cs=%b want 3 0", stat_code, sw_cs); else n_pass++;
        cmd(OP_ACK, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd0) $display("FAIL ovr_ack: got %0d want 0", stat_code); else n_pass++;
    endtask

    task automatic test_powerdown();
        cmd(OP_DISABLE, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd7 || stat_addr !== 6'd0) $display("FAIL pdn: got stat=%0d addr=%0d want 7 0", stat_code, stat_addr); else n_pass++;
        cmd(OP_READ, 6'd5, 1'b0);
        n_total++; if (stat_code !== 3'd7 || sw_cs !== 1'b0) $display("FAIL pdn_read: got stat=%0d cs=%b want 7 0", stat_code, sw_cs); else n_pass++;
        cmd(OP_ENABLE, 6'd0, 1'b0);
        n_total++; if (stat_code !== 3'd0 || stat_addr !== 6'd9) $display("FAIL pdn_enable: got stat=%0d addr=%0d want 0 9", stat_code, stat_addr); else n_pass++;
    endtask

    task automatic test_reset_cmd();
        cmd(OP_RESET, 6'd0, 1'b0);
        n_total++; if (reset !== 1'b1 || sw_cs !== 1'b1 || sw_we !== 1'b1 || sw_add !== 6'd0 || sw_wdat !== 128'h0)
            $display("FAIL rstcmd: got reset=%b cs=%b we=%b add=%0d wdat=%h want 1 1 1 0 0", reset, sw_cs, sw_we, sw_add, sw_wdat); else n_pass++;
        @(negedge clk);
        n_total++; if (reset !== 1'b0 || stat_code !== 3'd0) $display("FAIL rstcmd_end: got reset=%b stat=%0d want 0 0", reset, stat_code); else n_pass++;
        // Init pointer was left at 5 by INIT_INC; RESET must have cleared it.
        grant = 1'b1;
        cmd(OP_INIT, 6'd1, 1'b0);
        n_total++; if (sw_add !== 6'd0 || sw_wdat !== 128'd10) $display("FAIL init0: got add=%0d wdat=%h want 0 a", sw_add, sw_wdat); else n_pass++;
        @(negedge clk);
        n_total++; if (sw_add !== 6'd1 || sw_wdat !== 128'd10) $display("FAIL init1: got add=%0d wdat=%h want 1 a", sw_add, sw_wdat); else n_pass++;
        @(negedge clk);
        grant = 1'b0;
        n_total++; if (stat_code !== 3'd0 || sw_cs !== 1'b0) $display("FAIL init_done: got stat=%0d cs=%b want 0 0", stat_code, sw_cs); else n_pass++;
    endtask

    task automatic test_async_reset();
        cmd(OP_WRITE, 6'd2, 1'b0);
        n_total++; if (sw_cs !== 1'b1) $display("FAIL arst_pre: got cs=%b want 1", sw_cs); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (sw_cs !== 1'b0 || stat_code !== 3'd0 || rd_dat !== 128'h0) $display("FAIL arst: got cs=%b stat=%0d dat=%h want 0 0 0", sw_cs, stat_code, rd_dat); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (sw_cs !== 1'b0 || stat_code !== 3'd0) $display("FAIL arst_post: got cs=%b stat=%0d want 0 0", sw_cs, stat_code); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nxm();
        test_uop();
        test_init_inc();
        test_timeout();
        test_overrun();
        test_powerdown();
        test_reset_cmd();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nx_indirect_access_mw_cntrl.md
Name: nx_indirect_access_mw_cntrl

Overview:
- Next-generation indirect-access controller for register-mapped tables.
- Data width may exceed the register width; a staging buffer of N_WORDS words is loaded and read through register writes.
- Supports N_TABLES tables, each with its own address limit, a parametrised grant timer, and INIT_INC fill.
- Sits between the CSR decoder and one or more SRAM/flop tables that share a memory port with the datapath.

Parameters:
- CMND_ADDRESS, 11'h40C: register address of the command word.
- DATA_ADDRESS, 11'h410: base register address of the data words; word i is at DATA_ADDRESS+i.
- N_REG_ADDR_BITS, 11: register address width.
- N_WORD_BITS, 32: register data width.
- N_DATA_BITS, 128: table entry width. N_WORDS = ceil(N_DATA_BITS/N_WORD_BITS), at most 31.
- N_TABLES, 2: number of tables. TW = max(1, clog2(N_TABLES)).
- N_ENTRIES, 64: maximum entries per table. AW = clog2(N_ENTRIES).
- N_TIMER_BITS, 4: grant-wait timer width, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- wr_stb  in  1  register write strobe
- reg_addr  in  N_REG_ADDR_BITS  register address
- wr_dat  in  N_WORD_BITS  register write data
- cmnd_op  in  4  opcode: NOP0 READ1 WRITE2 ENABLE3 DISABLE4 RESET5 INIT6 INIT_INC7 SET_INIT_START8 SIM_TMO14 ACK_ERROR15
- cmnd_addr  in  AW  command entry address
- cmnd_table_id  in  TW  command table select
- addr_limit  in  N_TABLES*AW  per-table last valid address
- stat_code  out  3  RDY0 BSY1 TMO2 OVR3 NXM4 UOP5 PDN7
- stat_datawords  out  5  constant N_WORDS
- stat_addr  out  AW  addr_limit of the selected table; 0 while powered down
- stat_table_id  out  TW  table id latched by the last issued command
- rd_dat  out  N_DATA_BITS  staging buffer contents
- sw_cs  out  1  memory request
- sw_we  out  1  write qualifier
- sw_add  out  AW  memory address
- sw_table_id  out  TW  table select
- sw_wdat  out  N_DATA_BITS  write data
- sw_rdat  in  N_DATA_BITS  read data, valid the cycle after grant
- grant  in  1  memory port grant
- yield  out  1  asks the datapath to release the port
- reset  out  1  pulse marking a RESET write

Behaviour:
- Reset values: stat_code=0, state=READY, buffer=0, sw_cs=0, sw_we=0, reset=0, yield=0, timer=0, init pointer=0, latched table id=0.
- Data-word writes:
  - A write to DATA_ADDRESS+i (i<N_WORDS) loads buffer word i.
  - The top word is zero-extended.
  - Writes are accepted in every state except DO_READ and READ_DONE; in those two states they are ignored.
- Command decode: a command is a write to CMND_ADDRESS. Every op except NOP and SIM_TMO sets cmnd_issued. Undefined ops raise UOP.
- Address check (NXM): badaddr = cmnd_issued && (cmnd_addr > addr_limit[table] || cmnd_table_id >= N_TABLES). badaddr overrides all other transitions and goes to ERROR.
- State transitions:
  - READY: WRITE->DO_WRITE, READ->DO_READ, RESET->DO_RESET, INIT or INIT_INC->DO_INIT, DISABLE->POWERDOWN, undefined->ERROR (UOP). SET_INIT_START loads the init pointer from cmnd_addr.
  - DO_WRITE: sw_cs=sw_we=1, sw_wdat=buffer. On grant -> READY.
  - DO_READ: sw_cs=1. On grant -> READ_DONE. In READ_DONE the buffer takes sw_rdat, then -> READY. Total latency is grant+1 cycles.
  - DO_RESET: one cycle with sw_cs=sw_we=1, reset=1, sw_wdat=0, sw_add=0. Resets the init pointer to 0, then -> READY.
  - DO_INIT: sw_cs=sw_we=1, sw_add=init pointer. On each grant the pointer increments. The cycle where grant and pointer==cmnd_addr coincide -> READY. INIT writes the buffer to every entry. INIT_INC writes the buffer and adds 1 to buffer word 0 per granted write, modulo 2^N_WORD_BITS.
  - POWERDOWN: stat=PDN, memory idle. ENABLE -> READY; all other commands are ignored.
  - ERROR: stat is held. ACK_ERROR -> READY, or -> POWERDOWN if the error was entered from POWERDOWN.
- Overrun and timeout:
  - A new command issued while in any busy state -> ERROR with OVR.
  - The timer counts every busy cycle without grant and clears on grant.
  - yield = timer MSB.
  - Timer all-ones -> ERROR with TMO, and the request drops.
- ERROR code priority when entering ERROR: UOP > NXM > TMO > OVR.
- stat_code=BSY in every busy state. The new code is visible the cycle after the command.
- Asynchronous reset during any operation returns to READY immediately, with no memory access in flight.

Optional Feature:
- NX_IA_SIM_TMO_EN defined: SIM_TMO masks grant internally until the next timeout, to exercise the TMO path.
- NX_IA_SIM_TMO_EN undefined: op 14 is an undefined op -> ERROR with UOP.

Test Plan:
- Write words 0..3 = 32'h11111111..32'h44444444, then WRITE with table 1, addr 5, grant after 2 cycles -> sw_wdat=128'h44444444_33333333_22222222_11111111, sw_table_id=1, sw_add=5; stat BSY then RDY.
- READ with addr 5, grant immediately, sw_rdat=128'hA5 -> rd_dat=128'hA5 two cycles after the command, stat=RDY.
- addr_limit[0]=9, WRITE with addr 10 -> stat=NXM, no sw_cs; ACK_ERROR -> RDY.
- SET_INIT_START 2, buffer word0=7, INIT_INC to addr 4, grant always high -> writes at 2/3/4 with word0 = 7/8/9, then RDY.
- WRITE with grant held low -> yield=1 at timer 8, TMO at timer 15; a second command issued during BSY -> OVR.
- DISABLE -> PDN and stat_addr=0; READ is ignored; ENABLE -> RDY.
